// File: rtl/cpu_clock_pkg.sv
// Shared types for the 6309E clock generator: quarter-phase encoding and
// the phase -> (E,Q) mapping.
package cpu_clock_pkg;

   typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;

   typedef struct packed {
      logic e;
      logic q;
   } eq_t;

   // Q leads E by one quarter: 0=(0,0) 1=(0,1) 2=(1,1) 3=(1,0)
   function automatic eq_t phase_eq(input phase_t ph);
      eq_t r;
      case (ph)
         PH_0:    r = '{e: 1'b0, q: 1'b0};
         PH_1:    r = '{e: 1'b0, q: 1'b1};
         PH_2:    r = '{e: 1'b1, q: 1'b1};
         default: r = '{e: 1'b1, q: 1'b0};
      endcase
      return r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous level input; every stage
// resets to RST_VAL so the output is defined from the first cycle.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) sr <= {STAGES{RST_VAL}};
      else        sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/cpu_clock_gen.sv
// 6309E E/Q quadrature clock generator with runtime speed select, nWAIT
// stretching of phase 3, wait timeout and a free-running aux clock.
//
// state | meaning
// PH_0  | E=0 Q=0, E just fell (cyc_start), div_sel takes effect here
// PH_1  | E=0 Q=1
// PH_2  | E=1 Q=1, E just rose (e_rise)
// PH_3  | E=1 Q=0, may be held in quarter steps while wait_s is low
module cpu_clock_gen
   import cpu_clock_pkg::*;
#(
   parameter int DIV_FAST    = 4,
   parameter int DIV_SLOW    = 12,
   parameter int AUX_DIV     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int WAIT_MAX    = 16
) (
   input  logic MHZ48,
   input  logic nRESET,
   input  logic nWAIT,
   input  logic div_sel,
   input  logic tmo_clr,
   output logic MHZ12,
   output logic nE,
   output logic nQ,
   output logic cyc_start,
   output logic e_rise,
   output logic stretching,
   output logic wait_timeout
);

   localparam int PW = cnt_width(max_int(DIV_FAST, DIV_SLOW));
   localparam int SW = cnt_width(WAIT_MAX + 1);
   localparam int AW = cnt_width(AUX_DIV / 2);

   localparam logic [PW-1:0] TC_FAST = PW'(DIV_FAST - 1);
   localparam logic [PW-1:0] TC_SLOW = PW'(DIV_SLOW - 1);
   localparam logic [SW-1:0] SMAX    = SW'(WAIT_MAX);
   localparam logic [AW-1:0] AUX_TC  = AW'(AUX_DIV / 2 - 1);

   phase_t          phase;
   phase_t          ph_nxt;
   eq_t             eq_nxt;
   logic [PW-1:0]   presc;
   logic [PW-1:0]   tc_act;
   logic [SW-1:0]   scnt;
   logic [AW-1:0]   aux_cnt;
   logic            wait_s;
   logic            tc;
   logic            hold;
   logic            adv_p3;

   sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_wait_sync (
      .clk_sys (MHZ48),
      .rst_b   (nRESET),
      .d       (nWAIT),
      .q       (wait_s)
   );

   always_comb begin
      tc     = (presc == tc_act);
      hold   = (phase == PH_3) && !wait_s && (scnt < SMAX);
      adv_p3 = tc && (phase == PH_3) && !hold;
      ph_nxt = phase;
      if (tc && !hold) ph_nxt = phase_t'(phase + 2'd1);
      eq_nxt = phase_eq(ph_nxt);
   end

   always_ff @(posedge MHZ48 or negedge nRESET) begin
      if (!nRESET) begin
         phase        <= PH_0;
         presc        <= '0;
         tc_act       <= TC_FAST;
         scnt         <= '0;
         nE           <= 1'b1;
         nQ           <= 1'b1;
         cyc_start    <= 1'b0;
         e_rise       <= 1'b0;
         stretching   <= 1'b0;
         wait_timeout <= 1'b0;
      end else begin
         phase     <= ph_nxt;
         presc     <= tc ? '0 : presc + 1'b1;
         nE        <= ~eq_nxt.e;
         nQ        <= ~eq_nxt.q;
         cyc_start <= adv_p3;
         e_rise    <= tc && (phase == PH_1);

         if (tc && (phase == PH_3)) begin
            if (hold) begin
               scnt       <= scnt + 1'b1;
               stretching <= 1'b1;
            end else begin
               scnt       <= '0;
               stretching <= 1'b0;
               tc_act     <= div_sel ? TC_SLOW : TC_FAST;
            end
         end

         // a forced release beats a simultaneous clear
         if (adv_p3 && !wait_s) wait_timeout <= 1'b1;
         else if (tmo_clr)      wait_timeout <= 1'b0;
      end
   end

   always_ff @(posedge MHZ48 or negedge nRESET) begin
      if (!nRESET) begin
         aux_cnt <= AUX_TC;
         MHZ12   <= 1'b0;
      end else if (aux_cnt == '0) begin
         aux_cnt <= AUX_TC;
         MHZ12   <= ~MHZ12;
      end else begin
         aux_cnt <= aux_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Scoreboard bench for cpu_clock_gen: expected edge spacings are queued as
// stimulus is applied and compared as the DUT edges are observed.
module tb_cpu_clock_gen;

   logic MHZ48 = 1'b0;
   logic nRESET = 1'b0;
   logic nWAIT = 1'b1;
   logic div_sel = 1'b0;
   logic tmo_clr = 1'b0;
   logic MHZ12, nE, nQ, cyc_start, e_rise, stretching, wait_timeout;

   localparam int S_NE = 0, S_NQ = 1, S_CYC = 2, S_ERISE = 3, S_STR = 4, S_AUX = 5;

   int n_vec = 0;
   int n_bad = 0;
   int exp_q[$];
   int cyc = 0;

   cpu_clock_gen #(
      .DIV_FAST(4), .DIV_SLOW(12), .AUX_DIV(4), .SYNC_STAGES(2), .WAIT_MAX(16)
   ) dut (
      .MHZ48        (MHZ48),
      .nRESET       (nRESET),
      .nWAIT        (nWAIT),
      .div_sel      (div_sel),
      .tmo_clr      (tmo_clr),
      .MHZ12        (MHZ12),
      .nE           (nE),
      .nQ           (nQ),
      .cyc_start    (cyc_start),
      .e_rise       (e_rise),
      .stretching   (stretching),
      .wait_timeout (wait_timeout)
   );

   always #5 MHZ48 = ~MHZ48;
   always @(posedge MHZ48) cyc++;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input int obs);
      if (exp_q.size() == 0) chk({tag, "_noexp"}, obs, -1);
      else                   chk(tag, obs, exp_q.pop_front());
   endtask

   function automatic logic sig(input int id);
      case (id)
         S_NE:    return nE;
         S_NQ:    return nQ;
         S_CYC:   return cyc_start;
         S_ERISE: return e_rise;
         S_STR:   return stretching;
         S_AUX:   return MHZ12;
         default: return 1'bx;
      endcase
   endfunction

   // steps at least one cycle, then until sig(id)==val; returns cycles stepped
   task automatic wait_sig(input string tag, input int id, input logic val,
                           input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge MHZ48);
         cycles++;
      end while (sig(id) !== val && cycles < budget);
      if (sig(id) !== val) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic meas(input string tag, input int id, input logic val);
      int c;
      wait_sig(tag, id, val, 200, c);
      sb_pop(tag, c);
   endtask

   task automatic fresh_rise(input string tag, input int id);
      int c;
      wait_sig(tag, id, 1'b0, 200, c);
      wait_sig(tag, id, 1'b1, 200, c);
   endtask

   // from the phase-3 start sample, count cycles until nE rises
   task automatic meas_ph3(input string tag);
      int total, str;
      total = 0;
      str = 0;
      do begin
         @(negedge MHZ48);
         total++;
         if (stretching === 1'b1) str++;
      end while (nE !== 1'b1 && total < 400);
      if (nE !== 1'b1) chk({tag, "_timeout"}, 0, 1);
      sb_pop({tag, "_len"}, total);
      sb_pop({tag, "_str"}, str);
   endtask

   int   aux_bad = 0, aux_tog = 0, aux_last = 0;
   logic aux_prev = 1'b0;
   bit   aux_arm = 1'b0;
   always @(negedge MHZ48) begin
      if (!nRESET) begin
         aux_arm  = 1'b0;
         aux_prev = 1'b0;
      end else if (MHZ12 !== aux_prev) begin
         if (aux_arm && (cyc - aux_last) != 2) aux_bad++;
         aux_arm  = 1'b1;
         aux_last = cyc;
         aux_prev = MHZ12;
         aux_tog++;
      end
   end

   initial begin
      repeat (3) @(negedge MHZ48);
      chk("rst_ne", nE, 1);
      chk("rst_nq", nQ, 1);
      chk("rst_mhz12", MHZ12, 0);
      chk("rst_cyc_start", cyc_start, 0);
      chk("rst_e_rise", e_rise, 0);
      chk("rst_stretching", stretching, 0);
      chk("rst_timeout", wait_timeout, 0);

      // free-running fast cycle: 4 cycles per quarter
      nRESET = 1'b1;
      exp_q.push_back(4);  meas("first_nq_fall", S_NQ, 1'b0);
      exp_q.push_back(4);  meas("nq_to_ne_fall", S_NQ + S_NE * 0 - 1 + 1 == 1 ? S_NE : S_NE, 1'b0);
      chk("e_rise_with_ne_fall", e_rise, 1);
      exp_q.push_back(8);  meas("ne_low", S_NE, 1'b1);
      chk("cyc_start_with_ne_rise", cyc_start, 1);
      exp_q.push_back(8);  meas("ne_high", S_NE, 1'b0);
      exp_q.push_back(8);  meas("ne_fall_to_cyc", S_CYC, 1'b1);
      exp_q.push_back(1);  meas("cyc_start_width", S_CYC, 1'b0);
      exp_q.push_back(15); meas("cyc_period_rest", S_CYC, 1'b1);

      // nWAIT low only in phases 0/1: no stretch
      nWAIT = 1'b0;
      repeat (6) @(negedge MHZ48);
      nWAIT = 1'b1;
      exp_q.push_back(2);  meas("outside_to_ne_fall", S_NE, 1'b0);
      exp_q.push_back(8);  meas("outside_ne_low", S_NE, 1'b1);

      // nWAIT low 20 cycles from phase 2: 2-cycle sync leaves wait_s low for
      // the tc decisions 4,8,12,16 cycles into phase 3 -> 4 quarters added
      exp_q.push_back(8);  meas("w20_to_ph2", S_NE, 1'b0);
      nWAIT = 1'b0;
      fork
         begin
            repeat (20) @(negedge MHZ48);
            nWAIT = 1'b1;
         end
      join_none
      exp_q.push_back(4);  meas("w20_to_ph3", S_NQ, 1'b1);
      exp_q.push_back(20); exp_q.push_back(16); meas_ph3("w20_ph3");
      chk("w20_no_timeout", wait_timeout, 0);

      // nWAIT held: 16 extra quarters then forced release
      exp_q.push_back(8);  meas("wmax_to_ph2", S_NE, 1'b0);
      nWAIT = 1'b0;
      exp_q.push_back(4);  meas("wmax_to_ph3", S_NQ, 1'b1);
      exp_q.push_back(68); exp_q.push_back(64); meas_ph3("wmax_ph3");
      chk("wmax_timeout_set", wait_timeout, 1);
      nWAIT = 1'b1;
      repeat (5) @(negedge MHZ48);
      chk("timeout_sticky", wait_timeout, 1);
      tmo_clr = 1'b1;
      @(negedge MHZ48);
      tmo_clr = 1'b0;
      chk("timeout_cleared", wait_timeout, 0);

      // tmo_clr held across a forced release: set wins
      exp_q.push_back(2);  meas("wclr_to_ph2", S_NE, 1'b0);
      nWAIT = 1'b0;
      tmo_clr = 1'b1;
      exp_q.push_back(4);  meas("wclr_to_ph3", S_NQ, 1'b1);
      exp_q.push_back(68); exp_q.push_back(64); meas_ph3("wclr_ph3");
      chk("timeout_set_wins", wait_timeout, 1);
      tmo_clr = 1'b0;
      nWAIT = 1'b1;
      @(negedge MHZ48);
      chk("timeout_after_set_wins", wait_timeout, 1);

      // div_sel set in phase 1: current cycle fast, following cycles slow
      exp_q.push_back(3);  meas("ds_to_ph1", S_NQ, 1'b0);
      div_sel = 1'b1;
      exp_q.push_back(4);  meas("ds_cur_ne_fall", S_NE, 1'b0);
      exp_q.push_back(8);  meas("ds_cur_ne_low", S_NE, 1'b1);
      exp_q.push_back(24); meas("slow_ne_high", S_NE, 1'b0);
      exp_q.push_back(24); meas("slow_ne_low", S_NE, 1'b1);
      div_sel = 1'b0;
      exp_q.push_back(24); meas("slow2_ne_high", S_NE, 1'b0);
      exp_q.push_back(24); meas("slow2_ne_low", S_NE, 1'b1);
      exp_q.push_back(8);  meas("fast_again_ne_high", S_NE, 1'b0);
      exp_q.push_back(8);  meas("fast_again_ne_low", S_NE, 1'b1);

      // aux clock 2 high / 2 low
      fresh_rise("aux_sync", S_AUX);
      exp_q.push_back(2);  meas("aux_high", S_AUX, 1'b0);
      exp_q.push_back(2);  meas("aux_low", S_AUX, 1'b1);

      // reset asserted mid-stretch
      fresh_rise("rs_sync", S_NE);
      exp_q.push_back(8);  meas("rs_to_ph2", S_NE, 1'b0);
      nWAIT = 1'b0;
      exp_q.push_back(8);  meas("rs_to_stretch", S_STR, 1'b1);
      fresh_rise("rs_aux", S_AUX);
      chk("rs_stretch_before", stretching, 1);
      #2;
      nRESET = 1'b0;
      #1;
      chk("rs_ne", nE, 1);
      chk("rs_nq", nQ, 1);
      chk("rs_mhz12", MHZ12, 0);
      chk("rs_stretching", stretching, 0);
      chk("rs_timeout", wait_timeout, 0);
      chk("rs_cyc_start", cyc_start, 0);
      nWAIT = 1'b1;
      repeat (2) @(negedge MHZ48);
      nRESET = 1'b1;
      exp_q.push_back(4);  meas("rs_first_nq_fall", S_NQ, 1'b0);

      chk("aux_bad_intervals", aux_bad, 0);
      chk("aux_toggles_seen", int'(aux_tog > 100), 1);
      chk("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
